dac_sample_scheduler: RTL and testbench

//   Paces audio samples into the sigma-delta DAC at a fixed sample rate.

---
 rtl/dac_sample_scheduler.sv | 154 +++++++++++++++
 tb/tb_dac_sample_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_scheduler.sv
// ---------------------------------------------------------------------------
// dac_sample_scheduler
//   Paces audio samples into the sigma-delta DAC at a fixed sample rate.
//   Producers push codes over valid/ready into a small FIFO. Once the FIFO
//   has buffered START_LEVEL entries, one code is popped per sample period
//   and presented on the registered DAC code output. Starved sample periods
//   hold the last code and are counted; a disabled scheduler outputs
//   midscale with the FIFO flushed.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   enable         playback enable; low flushes the FIFO and forces midscale
//   sample_data    unsigned sample code from the producer
//   sample_valid   producer has a sample
//   sample_ready   FIFO accepts sample_data this cycle
//   code           registered code to the DAC
//   sample_tick    1-cycle pulse on the last cycle of each sample period
//   underrun_clr   clears underrun_count (wins over a same-cycle increment)
//   underrun_count saturating count of starved sample ticks
//   fifo_level     current FIFO occupancy
// ---------------------------------------------------------------------------
module dac_sample_scheduler #(
    parameter int unsigned CODE_WIDTH      = 10,
    parameter int unsigned CLKS_PER_SAMPLE = 2834,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned START_LEVEL     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [CODE_WIDTH-1:0]       sample_data,
    input  logic                        sample_valid,
    output logic                        sample_ready,
    output logic [CODE_WIDTH-1:0]       code,
    output logic                        sample_tick,
    input  logic                        underrun_clr,
    output logic [15:0]                 underrun_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = $clog2(CLKS_PER_SAMPLE);

    localparam logic [CODE_WIDTH-1:0] MID       = {1'b1, {(CODE_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(CLKS_PER_SAMPLE - 1);
    localparam logic [LEVEL_W-1:0]    LVL_FULL  = LEVEL_W'(FIFO_DEPTH);
    localparam logic [LEVEL_W-1:0]    LVL_START = LEVEL_W'(START_LEVEL);
    localparam logic [15:0]           URUN_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        RUN     = 2'd2,
        STARVED = 2'd3
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CODE_WIDTH-1:0] mem [FIFO_DEPTH];

    logic playing;
    logic push;
    logic pop;
    logic starve;

    // Sample-period decode from the registered tick counter.
    assign playing     = (state == RUN) || (state == STARVED);
    assign sample_tick = playing && (count == CNT_LAST);

    // No full bypass: a same-cycle pop does not open a slot.
    assign sample_ready = enable && (state != IDLE) && (fifo_level < LVL_FULL);
    assign push         = sample_valid && sample_ready;

    // RUN pops whatever is buffered; STARVED waits for a refill to START_LEVEL.
    always_comb begin
        pop = 1'b0;
        if (sample_tick && enable) begin
            if (state == RUN)
                pop = (fifo_level != '0);
            else
                pop = (fifo_level >= LVL_START);
        end
    end

    // Every tick that does not pop is a starved sample period.
    assign starve = sample_tick && enable && !pop;

    // FIFO storage; occupancy and pointers live with the FSM below.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= sample_data;
    end

    // Playback FSM, tick counter, FIFO bookkeeping and output code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            count          <= '0;
            code           <= MID;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level     <= '0;
            underrun_count <= '0;
        end else begin
            if (underrun_clr)
                underrun_count <= '0;
            else if (starve && (underrun_count != URUN_MAX))
                underrun_count <= underrun_count + 16'd1;

            if (!enable) begin
                // Flush; any pop pending this cycle is dropped.
                state      <= IDLE;
                count      <= '0;
                code       <= MID;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);

                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    code   <= mem[rd_ptr];
                end

                case ({push, pop})
                    2'b10:   fifo_level <= fifo_level + LEVEL_W'(1);
                    2'b01:   fifo_level <= fifo_level - LEVEL_W'(1);
                    default: fifo_level <= fifo_level;
                endcase

                // Counter is parked at 0 until playback, so RUN starts a full period.
                if (!playing || sample_tick)
                    count <= '0;
                else
                    count <= count + CNT_W'(1);

                case (state)
                    IDLE:    state <= FILL;
                    FILL:    if (fifo_level >= LVL_START) state <= RUN;
                    RUN:     if (sample_tick && !pop) state <= STARVED;
                    STARVED: if (pop) state <= RUN;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dac_sample_scheduler
//   Directed bench for dac_sample_scheduler with an 8-cycle sample period,
//   8-entry FIFO and start level 4. Inputs are driven and outputs sampled on
//   the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dac_sample_scheduler;

    localparam int unsigned CW    = 10;
    localparam int unsigned CPS   = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [CW-1:0] sample_data;
    logic          sample_valid;
    logic          sample_ready;
    logic [CW-1:0] code;
    logic          sample_tick;
    logic          underrun_clr;
    logic [15:0]   underrun_count;
    logic [LW-1:0] fifo_level;

    int errors = 0;
    int checks = 0;

    dac_sample_scheduler #(
        .CODE_WIDTH      (CW),
        .CLKS_PER_SAMPLE (CPS),
        .FIFO_DEPTH      (DEPTH),
        .START_LEVEL     (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .code           (code),
        .sample_tick    (sample_tick),
        .underrun_clr   (underrun_clr),
        .underrun_count (underrun_count),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;

    // Steps falling edges until sample_tick is seen; returns the step count (40 = timeout).
    task automatic wait_tick(output int n);
        n = 0;
        while (sample_tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_data = '0; underrun_clr = 1'b0;
        @(negedge clk);
        checks++; if (code !== 10'd512) begin errors++; $display("FAIL reset_code: got %0d want 512", code); end
        checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", sample_tick); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL reset_underrun: got %0d want 0", underrun_count); end
        enable = 1'b1;
        #1;
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", sample_ready); end
        enable = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (code !== 10'd512) begin errors++; $display("FAIL post_reset_code: got %0d want 512", code); end
    endtask

    task automatic test_playback();
        int n;
        int codes [4] = '{100, 200, 300, 400};
        enable = 1'b1;
        #1;
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b want 0", sample_ready); end
        @(negedge clk);
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL fill_ready: got %b want 1", sample_ready); end
        for (int i = 0; i < 4; i++) begin
            sample_data = CW'(codes[i]); sample_valid = 1'b1;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        checks++; if (fifo_level !== 4'd4) begin errors++; $display("FAIL fill_level: got %0d want 4", fifo_level); end
        wait_tick(n);
        checks++; if (n != 8) begin errors++; $display("FAIL first_tick_delay: got %0d want 8", n); end
        checks++; if (code !== 10'd512) begin errors++; $display("FAIL code_before_first_pop: got %0d want 512", code); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (code !== CW'(codes[i])) begin errors++; $display("FAIL play_code%0d: got %0d want %0d", i, code, codes[i]); end
            checks++; if (fifo_level !== LW'(3 - i)) begin errors++; $display("FAIL play_level%0d: got %0d want %0d", i, fifo_level, 3 - i); end
            if (i < 3) begin
                wait_tick(n);
                checks++; if (n != 7) begin errors++; $display("FAIL tick_period%0d: got %0d want 7", i, n); end
            end
        end
    endtask

    task automatic test_underrun();
        int n;
        wait_tick(n);
        checks++; if (n != 7) begin errors++; $display("FAIL starve_period: got %0d want 7", n); end
        @(negedge clk);
        checks++; if (code !== 10'd400) begin errors++; $display("FAIL starve_code: got %0d want 400", code); end
        checks++; if (underrun_count !== 16'd1) begin errors++; $display("FAIL starve_count: got %0d want 1", underrun_count); end
        // Three entries are below the restart level: the next tick must still starve.
        for (int i = 0; i < 3; i++) begin
            sample_data = CW'(500 + 100 * i); sample_valid = 1'b1;
            checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL starve_ready%0d: got %b want 1", i, sample_ready); end
            @(negedge clk);
        end
        sample_valid = 1'b0;
        wait_tick(n);
        checks++; if (n != 4) begin errors++; $display("FAIL starve_period2: got %0d want 4", n); end
        @(negedge clk);
        checks++; if (underrun_count !== 16'd2) begin errors++; $display("FAIL starve_count2: got %0d want 2", underrun_count); end
        checks++; if (code !== 10'd400) begin errors++; $display("FAIL starve_hold2: got %0d want 400", code); end
        sample_data = 10'd800; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        wait_tick(n);
        checks++; if (n != 6) begin errors++; $display("FAIL resume_period: got %0d want 6", n); end
        @(negedge clk);
        checks++; if (code !== 10'd500) begin errors++; $display("FAIL resume_code: got %0d want 500", code); end
        checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL resume_level: got %0d want 3", fifo_level); end
        checks++; if (underrun_count !== 16'd2) begin errors++; $display("FAIL resume_count: got %0d want 2", underrun_count); end
    endtask

    task automatic test_back_to_back();
        int n;
        int order [3] = '{700, 800, 900};
        wait_tick(n);
        checks++; if (n != 7) begin errors++; $display("FAIL b2b_period: got %0d want 7", n); end
        sample_data = 10'd900; sample_valid = 1'b1;
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", sample_ready); end
        @(negedge clk);
        sample_valid = 1'b0;
        checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL b2b_level: got %0d want 3", fifo_level); end
        checks++; if (code !== 10'd600) begin errors++; $display("FAIL b2b_code: got %0d want 600", code); end
        for (int i = 0; i < 3; i++) begin
            wait_tick(n);
            @(negedge clk);
            checks++; if (code !== CW'(order[i])) begin errors++; $display("FAIL b2b_order%0d: got %0d want %0d", i, code, order[i]); end
            checks++; if (fifo_level !== LW'(2 - i)) begin errors++; $display("FAIL b2b_drain%0d: got %0d want %0d", i, fifo_level, 2 - i); end
        end
    endtask

    task automatic test_underrun_clr();
        int n;
        wait_tick(n);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL clr_priority: got %0d want 0", underrun_count); end
        checks++; if (code !== 10'd900) begin errors++; $display("FAIL clr_code_hold: got %0d want 900", code); end
        wait_tick(n);
        @(negedge clk);
        checks++; if (underrun_count !== 16'd1) begin errors++; $display("FAIL starved_again: got %0d want 1", underrun_count); end
    endtask

    task automatic test_full();
        int n;
        enable = 1'b0;
        @(negedge clk);
        checks++; if (code !== 10'd512) begin errors++; $display("FAIL flush_code: got %0d want 512", code); end
        checks++; if (underrun_count !== 16'd1) begin errors++; $display("FAIL flush_keeps_count: got %0d want 1", underrun_count); end
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            sample_data = CW'(10 * (i + 1)); sample_valid = 1'b1;
            checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL full_push_ready%0d: got %b want 1", i, sample_ready); end
            @(negedge clk);
        end
        // A 9th sample stays offered, including across the pop tick.
        sample_data = 10'd999;
        for (int k = 0; k < 4; k++) begin
            checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL full_ready%0d: got %b want 0", k, sample_ready); end
            checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_level%0d: got %0d want 8", k, fifo_level); end
            @(negedge clk);
        end
        checks++; if (sample_tick !== 1'b1) begin errors++; $display("FAIL full_tick: got %b want 1", sample_tick); end
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got %b want 0", sample_ready); end
        @(negedge clk);
        sample_valid = 1'b0;
        checks++; if (fifo_level !== 4'd7) begin errors++; $display("FAIL full_pop_level: got %0d want 7", fifo_level); end
        checks++; if (code !== 10'd10) begin errors++; $display("FAIL full_pop_code: got %0d want 10", code); end
        n = 0;
    endtask

    task automatic test_disable();
        int n;
        wait_tick(n);
        @(negedge clk);
        wait_tick(n);
        @(negedge clk);
        checks++; if (code !== 10'd30) begin errors++; $display("FAIL dis_pre_code: got %0d want 30", code); end
        wait_tick(n);
        checks++; if (fifo_level !== 4'd5) begin errors++; $display("FAIL dis_pre_level: got %0d want 5", fifo_level); end
        enable = 1'b0;
        @(negedge clk);
        checks++; if (code !== 10'd512) begin errors++; $display("FAIL dis_code: got %0d want 512", code); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL dis_level: got %0d want 0", fifo_level); end
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL dis_ready: got %b want 0", sample_ready); end
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sample_data = CW'(111 * (i + 1)); sample_valid = 1'b1;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        wait_tick(n);
        checks++; if (n != 8) begin errors++; $display("FAIL refill_tick_delay: got %0d want 8", n); end
        @(negedge clk);
        checks++; if (code !== 10'd111) begin errors++; $display("FAIL refill_code: got %0d want 111", code); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (code !== 10'd512) begin errors++; $display("FAIL arst_code: got %0d want 512", code); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL arst_level: got %0d want 0", fifo_level); end
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL arst_ready: got %b want 0", sample_ready); end
        checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL arst_underrun: got %0d want 0", underrun_count); end
        checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL arst_tick: got %b want 0", sample_tick); end
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_playback();
        test_underrun();
        test_back_to_back();
        test_underrun_clr();
        test_full();
        test_disable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
